// File: rtl/reg_file.sv
// Architectural register file with per-register rename tags (busy flag + newest producer ROB index).
// Writes land on the next edge; operand reads are combinational with a same-cycle commit bypass.
module reg_file #(
  parameter int ROB_IDX_SIZE = 4,
  parameter int REG_NUM      = 32
) (
  input  logic                    clk,
  input  logic                    rst_in,
  input  logic                    rdy_in,
  input  logic                    roll_back,
  input  logic                    de_in_en,
  input  logic [4:0]              de_dest_in,
  input  logic [ROB_IDX_SIZE-1:0] de_rob_idx_in,
  input  logic [4:0]              rs1_idx_in,
  input  logic [4:0]              rs2_idx_in,
  output logic                    rs1_busy_out,
  output logic [ROB_IDX_SIZE-1:0] rs1_dep_out,
  output logic [31:0]             rs1_val_out,
  output logic                    rs2_busy_out,
  output logic [ROB_IDX_SIZE-1:0] rs2_dep_out,
  output logic [31:0]             rs2_val_out,
  input  logic                    rob_in_en,
  input  logic [ROB_IDX_SIZE-1:0] rob_rob_idx_in,
  input  logic [4:0]              rob_dest_in,
  input  logic [31:0]             rob_val_in
);

  logic [31:0]             regs [REG_NUM];
  logic [ROB_IDX_SIZE-1:0] dep  [REG_NUM];
  logic [REG_NUM-1:0]      busy;

  logic issue_ok;
  logic commit_ok;

  assign issue_ok  = de_in_en && (de_dest_in != 5'd0) && !roll_back;
  assign commit_ok = rob_in_en && (rob_dest_in != 5'd0);

  // The issue update comes after the commit clear so a same-cycle rename of the
  // committing register keeps it busy under the new tag.
  always_ff @(posedge clk) begin
    if (rst_in) begin
      for (int i = 0; i < REG_NUM; i++) begin
        regs[i] <= '0;
        dep[i]  <= '0;
      end
      busy <= '0;
    end else if (rdy_in) begin
      if (commit_ok) begin
        regs[rob_dest_in] <= rob_val_in;
        if (dep[rob_dest_in] == rob_rob_idx_in)
          busy[rob_dest_in] <= 1'b0;
      end
      if (roll_back)
        busy <= '0;
      else if (issue_ok) begin
        busy[de_dest_in] <= 1'b1;
        dep[de_dest_in]  <= de_rob_idx_in;
      end
    end
  end

  always_comb begin
    rs1_busy_out = 1'b0;
    rs1_dep_out  = '0;
    rs1_val_out  = '0;
    if (rs1_idx_in != 5'd0) begin
      rs1_dep_out = dep[rs1_idx_in];
      if (rob_in_en && (rob_dest_in == rs1_idx_in) && (dep[rs1_idx_in] == rob_rob_idx_in)) begin
        rs1_val_out = rob_val_in;
      end else begin
        rs1_busy_out = busy[rs1_idx_in];
        rs1_val_out  = regs[rs1_idx_in];
      end
    end
  end

  always_comb begin
    rs2_busy_out = 1'b0;
    rs2_dep_out  = '0;
    rs2_val_out  = '0;
    if (rs2_idx_in != 5'd0) begin
      rs2_dep_out = dep[rs2_idx_in];
      if (rob_in_en && (rob_dest_in == rs2_idx_in) && (dep[rs2_idx_in] == rob_rob_idx_in)) begin
        rs2_val_out = rob_val_in;
      end else begin
        rs2_busy_out = busy[rs2_idx_in];
        rs2_val_out  = regs[rs2_idx_in];
      end
    end
  end

endmodule

// File: tb/tb_reg_file.sv
// Scoreboard bench for reg_file: stimulus pushes hand-computed expectations,
// a negedge monitor pops them and compares against the combinational read ports.
module tb_reg_file;

  logic        clk;
  logic        rst_in;
  logic        rdy_in;
  logic        roll_back;
  logic        de_in_en;
  logic [4:0]  de_dest_in;
  logic [3:0]  de_rob_idx_in;
  logic [4:0]  rs1_idx_in;
  logic [4:0]  rs2_idx_in;
  logic        rs1_busy_out;
  logic [3:0]  rs1_dep_out;
  logic [31:0] rs1_val_out;
  logic        rs2_busy_out;
  logic [3:0]  rs2_dep_out;
  logic [31:0] rs2_val_out;
  logic        rob_in_en;
  logic [3:0]  rob_rob_idx_in;
  logic [4:0]  rob_dest_in;
  logic [31:0] rob_val_in;

  reg_file #(.ROB_IDX_SIZE(4), .REG_NUM(32)) dut (
    .clk(clk), .rst_in(rst_in), .rdy_in(rdy_in), .roll_back(roll_back),
    .de_in_en(de_in_en), .de_dest_in(de_dest_in), .de_rob_idx_in(de_rob_idx_in),
    .rs1_idx_in(rs1_idx_in), .rs2_idx_in(rs2_idx_in),
    .rs1_busy_out(rs1_busy_out), .rs1_dep_out(rs1_dep_out), .rs1_val_out(rs1_val_out),
    .rs2_busy_out(rs2_busy_out), .rs2_dep_out(rs2_dep_out), .rs2_val_out(rs2_val_out),
    .rob_in_en(rob_in_en), .rob_rob_idx_in(rob_rob_idx_in),
    .rob_dest_in(rob_dest_in), .rob_val_in(rob_val_in)
  );

  typedef struct {
    string       name;
    bit          port;
    logic        busy;
    logic [3:0]  dep;
    logic [31:0] val;
    bit          full;
  } exp_t;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Without 'full', dep is only meaningful when busy and val only when not busy.
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      exp_t        e;
      logic        ab;
      logic [3:0]  ad;
      logic [31:0] av;
      bit          bad;
      e   = exp_q.pop_front();
      ab  = e.port ? rs2_busy_out : rs1_busy_out;
      ad  = e.port ? rs2_dep_out  : rs1_dep_out;
      av  = e.port ? rs2_val_out  : rs1_val_out;
      bad = (ab !== e.busy) ||
            ((e.full || e.busy)  && (ad !== e.dep)) ||
            ((e.full || !e.busy) && (av !== e.val));
      vectors++;
      if (bad) begin
        miscompares++;
        $display("[TB] FAIL %s: got busy=%0b dep=%0d val=%h, want busy=%0b dep=%0d val=%h",
                 e.name, ab, ad, av, e.busy, e.dep, e.val);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic de_en, input logic [4:0] de_dest, input logic [3:0] de_idx,
                               input logic rb_en, input logic [3:0] rb_idx, input logic [4:0] rb_dest,
                               input logic [31:0] rb_val, input logic [4:0] rs1, input logic [4:0] rs2);
    de_in_en       = de_en;
    de_dest_in     = de_dest;
    de_rob_idx_in  = de_idx;
    rob_in_en      = rb_en;
    rob_rob_idx_in = rb_idx;
    rob_dest_in    = rb_dest;
    rob_val_in     = rb_val;
    rs1_idx_in     = rs1;
    rs2_idx_in     = rs2;
  endtask

  task automatic checkOutput(input string name, input bit port, input logic busy,
                             input logic [3:0] dep, input logic [31:0] val, input bit full);
    exp_t e;
    e.name = name;
    e.port = port;
    e.busy = busy;
    e.dep  = dep;
    e.val  = val;
    e.full = full;
    exp_q.push_back(e);
  endtask

  initial begin
    rst_in    = 1'b1;
    rdy_in    = 1'b1;
    roll_back = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    rst_in = 1'b0;

    // Reset state
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 5, 0);
    checkOutput("reset_x5", 0, 0, 0, 0, 1);
    checkOutput("reset_x0", 1, 0, 0, 0, 1);
    tick();

    // Rename x3 -> idx2, then commit it
    applyStimulus(1, 3, 2, 0, 0, 0, 0, 3, 0);
    checkOutput("issue_not_visible_x3", 0, 0, 0, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 3, 0);
    checkOutput("x3_busy_dep2", 0, 1, 2, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 1, 2, 3, 32'hDEADBEEF, 3, 0);
    checkOutput("x3_commit_bypass", 0, 0, 0, 32'hDEADBEEF, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 3, 0);
    checkOutput("x3_after_commit", 0, 0, 0, 32'hDEADBEEF, 0);
    tick();

    // Two producers for x4: older commit must not clear busy
    applyStimulus(1, 4, 1, 0, 0, 0, 0, 0, 0);
    tick();
    applyStimulus(1, 4, 5, 0, 0, 0, 0, 4, 0);
    checkOutput("x4_prev_producer", 0, 1, 1, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 1, 1, 4, 32'd7, 4, 0);
    checkOutput("x4_old_commit_no_bypass", 0, 1, 5, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 4, 0);
    checkOutput("x4_still_busy", 0, 1, 5, 32'd7, 1);
    tick();
    applyStimulus(0, 0, 0, 1, 5, 4, 32'd9, 0, 4);
    checkOutput("x4_young_commit_bypass", 1, 0, 0, 32'd9, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 4, 0);
    checkOutput("x4_free", 0, 0, 0, 32'd9, 0);
    tick();

    // Same-cycle commit and re-issue of x6
    applyStimulus(1, 6, 3, 0, 0, 0, 0, 0, 0);
    tick();
    applyStimulus(1, 6, 4, 1, 3, 6, 32'h0000ABCD, 6, 0);
    checkOutput("x6_same_cycle_bypass", 0, 0, 0, 32'h0000ABCD, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 6, 0);
    checkOutput("x6_issue_priority", 0, 1, 4, 32'h0000ABCD, 1);
    tick();

    // Roll back with concurrent commit and issue
    applyStimulus(1, 1, 6, 0, 0, 0, 0, 0, 0);
    tick();
    applyStimulus(1, 2, 7, 0, 0, 0, 0, 0, 0);
    tick();
    applyStimulus(1, 7, 8, 0, 0, 0, 0, 2, 0);
    checkOutput("x2_busy_dep7", 0, 1, 7, 0, 0);
    tick();
    roll_back = 1'b1;
    applyStimulus(1, 9, 9, 1, 7, 2, 32'h55, 1, 2);
    checkOutput("rb_read_x1_busy", 0, 1, 6, 0, 0);
    checkOutput("rb_read_x2_bypass", 1, 0, 0, 32'h55, 0);
    tick();
    roll_back = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 2, 9);
    checkOutput("rb_x2_value", 0, 0, 0, 32'h55, 0);
    checkOutput("rb_x9_not_busy", 1, 0, 0, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 7);
    checkOutput("rb_x1_clear", 0, 0, 0, 0, 0);
    checkOutput("rb_x7_clear", 1, 0, 0, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 6, 0);
    checkOutput("rb_x6_clear_keeps_val", 0, 0, 0, 32'h0000ABCD, 0);
    tick();

    // x0 writes dropped, and its read never takes the bypass
    applyStimulus(1, 0, 3, 1, 0, 0, 32'h1234, 0, 0);
    checkOutput("x0_bypass_blocked", 0, 0, 0, 0, 1);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("x0_zero", 0, 0, 0, 0, 1);
    checkOutput("x0_zero_rs2", 1, 0, 0, 0, 1);
    tick();

    // Stall: issue x10 and commit x4 are both ignored
    rdy_in = 1'b0;
    applyStimulus(1, 10, 2, 1, 5, 4, 32'h77, 0, 0);
    tick();
    rdy_in = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 10, 4);
    checkOutput("stall_x10_not_busy", 0, 0, 0, 0, 0);
    checkOutput("stall_x4_unchanged", 1, 0, 0, 32'd9, 0);
    tick();

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
